// File: rtl/membus_responder.sv
// membus_responder: 6502 bus target serving zero-page RAM, vectors and an optional interval timer.
// Define MEMBUS_TIMER_EN to build the timer registers at $E000-$E003 and the irq output.
module membus_responder #(
    parameter logic [15:0] RESET_VEC = 16'hFF00,
    parameter logic [15:0] NMI_VEC   = 16'hFF00,
    parameter logic [15:0] IRQ_VEC   = 16'hFF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk1,
    input  logic        clk2,
    input  logic [15:0] addr,
    input  logic        rw,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        irq
);
    logic phi1_edge;
    logic phi2_edge;
    logic ram_hit;

    // Overlapping or absent qualifiers must neither capture nor commit.
    assign phi1_edge = clk1 & ~clk2;
    assign phi2_edge = clk2 & ~clk1;
    assign ram_hit   = (addr[15:8] == 8'h00);

    logic [7:0] ram [0:255];
    logic [7:0] ram_rd_reg;

    always_ff @(posedge clk) begin
        if (phi2_edge && !rw && ram_hit)
            ram[addr[7:0]] <= wdata;
        if (phi1_edge)
            ram_rd_reg <= ram[addr[7:0]];
    end

`ifdef MEMBUS_TIMER_EN
    logic [15:0] counter_reg;
    logic [7:0]  reload_lo_reg;
    logic [7:0]  reload_hi_reg;
    logic [2:0]  ctrl_reg;
    logic        expired_reg;
    logic        status_rd_reg;
    logic        irq_reg;
    logic        expire_now;

    assign expire_now = ctrl_reg[0] && (counter_reg == 16'h0000);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            counter_reg   <= 16'h0000;
            reload_lo_reg <= 8'h00;
            reload_hi_reg <= 8'h00;
            ctrl_reg      <= 3'b000;
            expired_reg   <= 1'b0;
            status_rd_reg <= 1'b0;
            irq_reg       <= 1'b0;
        end else begin
            irq_reg <= expired_reg & ctrl_reg[1];
            if (phi1_edge)
                status_rd_reg <= rw && (addr == 16'hE003);
            if (phi2_edge) begin
                status_rd_reg <= 1'b0;
                if (ctrl_reg[0]) begin
                    if (expire_now) begin
                        if (ctrl_reg[2])
                            counter_reg <= {reload_hi_reg, reload_lo_reg};
                        else
                            ctrl_reg[0] <= 1'b0;
                    end else begin
                        counter_reg <= counter_reg - 16'd1;
                    end
                end
                // A new expiry beats the clear from a status read on the same edge.
                if (expire_now)
                    expired_reg <= 1'b1;
                else if (status_rd_reg)
                    expired_reg <= 1'b0;
                // Bus writes come last so they override the timer's own update.
                if (!rw) begin
                    case (addr)
                        16'hE000: reload_lo_reg <= wdata;
                        16'hE001: begin
                            reload_hi_reg <= wdata;
                            counter_reg   <= {wdata, reload_lo_reg};
                        end
                        16'hE002: ctrl_reg <= wdata[2:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    assign irq = irq_reg;
`else
    assign irq = 1'b0;
`endif

    logic [7:0] reg_rd_next;
    logic [7:0] reg_rd_reg;
    logic       ram_sel_reg;

    always_comb begin
        reg_rd_next = 8'hFF;
        case (addr)
            16'hFFFA: reg_rd_next = NMI_VEC[7:0];
            16'hFFFB: reg_rd_next = NMI_VEC[15:8];
            16'hFFFC: reg_rd_next = RESET_VEC[7:0];
            16'hFFFD: reg_rd_next = RESET_VEC[15:8];
            16'hFFFE: reg_rd_next = IRQ_VEC[7:0];
            16'hFFFF: reg_rd_next = IRQ_VEC[15:8];
`ifdef MEMBUS_TIMER_EN
            16'hE000: reg_rd_next = reload_lo_reg;
            16'hE001: reg_rd_next = reload_hi_reg;
            16'hE002: reg_rd_next = {5'b00000, ctrl_reg};
            16'hE003: reg_rd_next = {7'b0000000, expired_reg};
`endif
            default:  reg_rd_next = 8'hFF;
        endcase
    end

    // RAM read stays in its own unreset register; the select steers rdata to $FF on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ram_sel_reg <= 1'b0;
            reg_rd_reg  <= 8'hFF;
        end else if (phi1_edge) begin
            ram_sel_reg <= ram_hit;
            reg_rd_reg  <= reg_rd_next;
        end
    end

    assign rdata = ram_sel_reg ? ram_rd_reg : reg_rd_reg;

endmodule

// File: doc/membus_responder.md
# membus_responder

Memory-mapped bus responder for the `cpu6502` core: the target end of the CPU's address/data bus. It decodes `addr`/`rw` on the two-phase bus, serves a 256-byte zero-page RAM, read-only interrupt/reset vectors and a 16-bit down-counting interval timer that drives the CPU `irq` input. It replaces ad-hoc combinational ROM models in system-level benches and FPGA top levels.

## Interface
- `RESET_VEC`, 16'hFF00, value returned at $FFFC (lo) / $FFFD (hi)
- `NMI_VEC`, 16'hFF00, value returned at $FFFA / $FFFB
- `IRQ_VEC`, 16'hFF00, value returned at $FFFE / $FFFF
- `clk`  in  1  system clock; all state changes on rising edge
- `reset`  in  1  asynchronous, active-low reset; one clock, no other clock domain
- `clk1`  in  1  phi1 qualifier from CPU (high during address phase)
- `clk2`  in  1  phi2 qualifier from CPU (high during data phase)
- `addr`  in  16  CPU address
- `rw`  in  1  1 = read, 0 = write
- `wdata`  in  8  CPU write data (CPU `odata`)
- `rdata`  out  8  read data to CPU (`idata`)
- `irq`  out  1  level interrupt request, active-high

## Operation
- One CPU bus cycle = 2 `clk` cycles: phi1 clock (`clk1`=1) then phi2 clock (`clk2`=1).
- Address map: $0000-$00FF RAM (256x8); $E000 reload lo; $E001 reload hi; $E002 control; $E003 status; $FFFA-$FFFF vectors; all else unmapped.
- Unmapped reads return $FF; unmapped writes ignored. Vector writes ignored.
- Read: `rdata` registered on the rising edge where `clk1`=1, from `addr` at that edge; held until next phi1 edge.
- Write: committed on rising edge where `clk2`=1 and `rw`=0, using `addr`/`wdata` at that edge.
- RAM contents not reset (undefined after power-up).
- Control bits: [0] enable, [1] irq enable, [2] auto-reload, [7:3] read 0, writes ignored.
- Writing $E001 stores reload hi and loads counter with {wdata, reload_lo}.
- Timer steps on each phi2 edge while enable=1: counter==0 → set status[0] (expired), then reload counter if auto-reload else clear enable; otherwise decrement. Period = reload+1 CPU cycles.
- Status $E003: [0] expired flag, [7:1] read 0. A read of $E003 clears the flag on the phi2 edge of that read cycle; writes to $E003 ignored.
- `irq` = registered (expired & irq enable).
- Counter arithmetic 16-bit unsigned; reload $0000 with auto-reload expires every cycle.

## Timing
- Reset (`reset`=0, async): `rdata`=$FF, `irq`=0, counter/reload/control/status=0; effective immediately, mid-cycle included.
- Read latency: data valid from the phi2 edge of the same bus cycle (1 `clk` after phi1 edge), stable through CPU sample at end of phi2.
- `irq` asserts 1 `clk` after the expiring phi2 edge; deasserts 1 `clk` after the clearing phi2 edge.
- Simultaneous expire and status-read clear on same edge: set wins, flag remains 1; the read returns pre-expire value.
- Simultaneous $E001 write and expire: write load wins; expiry still sets the flag.
- `clk1` and `clk2` both 0 or both 1: no read capture, no write commit, timer holds.

## Configuration
- `MEMBUS_TIMER_EN` defined: timer registers and `irq` as above.
- Undefined: $E000-$E003 unmapped (read $FF, writes ignored), no timer logic, `irq` tied 0.

## Test plan
- Release reset, CPU fetches $FFFC then $FFFD → `rdata` $00 then $FF (RESET_VEC=$FF00); during reset `rdata`=$FF.
- Write $5A to $0042, read $0042 → $5A; read $1234 → $FF; write $AA to $FFFC then read → still $00.
- Reload=$0003, control=$03 → `irq`=1 one clk after 4th phi2 edge; control reads $02; read $E003 → $01, `irq`=0 one clk later.
- Reload=$0001, control=$07 → flag sets every 2 CPU cycles; status read on expiry edge leaves `irq`=1.
- Drop `reset` mid-count between clk edges → `irq`=0, `rdata`=$FF before next edge; $E002 reads $00 afterward.
- Build without `MEMBUS_TIMER_EN`: write $07 to $E002, read $E002 → $FF, `irq` stays 0 for 100 cycles.
